// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// -----------------------------------------------------------------------------
// Receive-side frame decoder for the player-link UART. Pops every byte the
// UART receive FIFO offers and hunts for SYNC_BYTE. It then collects
// PAYLOAD_BYTES data bytes and checks a trailing XOR checksum. A good frame is
// published on `payload` together with a one-cycle `frame_valid` strobe.
// Link health is tracked with an inter-byte timeout, which aborts partial
// frames, and a link timeout, which drops `link_up`.
//
// Optional build macro: UART_FRAME_RX_STATS_EN
//   defined   -> saturating 8-bit checksum-error / timeout counters
//   undefined -> chk_err_cnt / to_err_cnt tied to 8'h00, no counter logic
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   rx_empty     UART rx FIFO empty flag
//   r_data       UART rx FIFO head byte, valid while rx_empty = 0
//   rd_uart      FIFO pop (= !rx_empty); r_data consumed this cycle
//   payload      last valid payload, byte 0 in bits [7:0]
//   frame_valid  one-cycle pulse when payload updates
//   link_up      high while valid frames keep arriving
//   chk_err      one-cycle pulse on checksum mismatch
//   to_err       one-cycle pulse on inter-byte timeout abort
//   chk_err_cnt  saturating checksum-error count (stats build only)
//   to_err_cnt   saturating timeout count (stats build only)
// -----------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int unsigned PAYLOAD_BYTES = 3,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT  = 40000,
    parameter int unsigned LINK_TIMEOUT  = 6500000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_empty,
    input  logic [7:0]                 r_data,
    output logic                       rd_uart,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       frame_valid,
    output logic                       link_up,
    output logic                       chk_err,
    output logic                       to_err,
    output logic [7:0]                 chk_err_cnt,
    output logic [7:0]                 to_err_cnt
);

    localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned BT_W  = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam int unsigned LT_W  = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [LT_W-1:0]  LT_LAST  = LT_W'(LINK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    // Running XOR checksum step
    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                       state_r, next_state_s;
    logic [8*PAYLOAD_BYTES-1:0]   shadow_r;
    logic [8*PAYLOAD_BYTES-1:0]   payload_r;
    logic [IDX_W-1:0]             idx_r;
    logic [7:0]                   chk_r;
    logic [BT_W-1:0]              byte_tmr_r;
    logic [LT_W-1:0]              link_tmr_r;
    logic                         frame_valid_r, link_up_r, chk_err_r, to_err_r;

    logic pop_s;
    logic start_s;       // sync byte accepted in HUNT
    logic store_s;       // payload byte written to shadow
    logic frame_ok_s;    // checksum byte matched
    logic frame_bad_s;   // checksum byte mismatched
    logic timeout_s;     // inter-byte timer expired with no byte
    logic tick_s;        // inter-byte timer advances this cycle

    // The block never back-pressures: every offered byte is popped.
    assign pop_s   = ~rx_empty;
    assign rd_uart = pop_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        store_s      = 1'b0;
        frame_ok_s   = 1'b0;
        frame_bad_s  = 1'b0;
        timeout_s    = 1'b0;
        tick_s       = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (pop_s && (r_data == SYNC_BYTE)) begin
                    start_s      = 1'b1;
                    next_state_s = ST_PAYLOAD;
                end else begin
                    next_state_s = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (pop_s) begin
                    store_s = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        next_state_s = ST_CHECK;
                    end else begin
                        next_state_s = ST_PAYLOAD;
                    end
                end else if (byte_tmr_r == BT_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_HUNT;
                end else begin
                    tick_s = 1'b1;
                end
            end
            ST_CHECK: begin
                if (pop_s) begin
                    if (r_data == chk_r) begin
                        frame_ok_s = 1'b1;
                    end else begin
                        frame_bad_s = 1'b1;
                    end
                    next_state_s = ST_HUNT;
                end else if (byte_tmr_r == BT_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_HUNT;
                end else begin
                    tick_s = 1'b1;
                end
            end
            default: begin
                next_state_s = ST_HUNT;
            end
        endcase
    end

    // Frame assembly: shadow buffer, byte index, checksum and inter-byte timer
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r   <= '0;
            idx_r      <= '0;
            chk_r      <= 8'h00;
            byte_tmr_r <= '0;
        end else begin
            // Timer runs only while waiting inside a frame; any byte or abort clears it.
            byte_tmr_r <= tick_s ? (byte_tmr_r + BT_W'(1)) : '0;
            if (start_s) begin
                idx_r <= '0;
                chk_r <= 8'h00;
            end else if (store_s) begin
                idx_r <= idx_r + IDX_W'(1);
                chk_r <= chk_step(chk_r, r_data);
            end else begin
                idx_r <= idx_r;
                chk_r <= chk_r;
            end
            for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
                if (store_s && (idx_r == IDX_W'(i))) begin
                    shadow_r[i*8 +: 8] <= r_data;
                end
            end
        end
    end

    // Published payload, result pulses and link supervision
    always_ff @(posedge clk) begin
        if (rst) begin
            payload_r     <= '0;
            frame_valid_r <= 1'b0;
            chk_err_r     <= 1'b0;
            to_err_r      <= 1'b0;
            link_up_r     <= 1'b0;
            link_tmr_r    <= '0;
        end else begin
            frame_valid_r <= frame_ok_s;
            chk_err_r     <= frame_bad_s;
            to_err_r      <= timeout_s;
            if (frame_ok_s) begin
                payload_r <= shadow_r;
            end else begin
                payload_r <= payload_r;
            end
            // Link timer saturates at its limit and holds link_up low until a good frame.
            if (frame_ok_s) begin
                link_tmr_r <= '0;
                link_up_r  <= 1'b1;
            end else if (link_tmr_r == LT_LAST) begin
                link_tmr_r <= link_tmr_r;
                link_up_r  <= 1'b0;
            end else begin
                link_tmr_r <= link_tmr_r + LT_W'(1);
                link_up_r  <= link_up_r;
            end
        end
    end

    assign payload     = payload_r;
    assign frame_valid = frame_valid_r;
    assign chk_err     = chk_err_r;
    assign to_err      = to_err_r;
    assign link_up     = link_up_r;

`ifdef UART_FRAME_RX_STATS_EN
    logic [7:0] chk_err_cnt_r, to_err_cnt_r;

    // Saturating error counters, updated on the same edge that raises each pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_cnt_r <= 8'h00;
            to_err_cnt_r  <= 8'h00;
        end else begin
            if (frame_bad_s && (chk_err_cnt_r != 8'hFF)) begin
                chk_err_cnt_r <= chk_err_cnt_r + 8'h01;
            end else begin
                chk_err_cnt_r <= chk_err_cnt_r;
            end
            if (timeout_s && (to_err_cnt_r != 8'hFF)) begin
                to_err_cnt_r <= to_err_cnt_r + 8'h01;
            end else begin
                to_err_cnt_r <= to_err_cnt_r;
            end
        end
    end

    assign chk_err_cnt = chk_err_cnt_r;
    assign to_err_cnt  = to_err_cnt_r;
`else
    assign chk_err_cnt = 8'h00;
    assign to_err_cnt  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx (PAYLOAD_BYTES=3, short timeouts).
module tb_uart_frame_rx;

    localparam int BT = 16;
    localparam int LT = 200;
`ifdef UART_FRAME_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic [23:0] payload;
    logic        frame_valid, link_up, chk_err, to_err;
    logic [7:0]  chk_err_cnt, to_err_cnt;

    uart_frame_rx #(
        .PAYLOAD_BYTES(3),
        .SYNC_BYTE    (8'hA5),
        .BYTE_TIMEOUT (BT),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .payload    (payload),
        .frame_valid(frame_valid),
        .link_up    (link_up),
        .chk_err    (chk_err),
        .to_err     (to_err),
        .chk_err_cnt(chk_err_cnt),
        .to_err_cnt (to_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_seen = 0;
    int ce_seen = 0;
    int te_seen = 0;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_valid) fv_seen++;
        if (chk_err)     ce_seen++;
        if (to_err)      te_seen++;
    end

    typedef struct {
        logic [63:0] bytes;   // byte 0 in [63:56]
        int          n;
        int          exp_fv;
        int          exp_ce;
        logic [23:0] exp_payload;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_empty = 1'b0;
        r_data   = b;
        @(posedge clk);
        #1;
        rx_empty = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_empty = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int fv0, ce0, te0;
        logic [7:0] b;

        vecs[0] = '{64'hA5FF000FF0000000, 5, 1, 0, 24'h0F00FF};
        vecs[1] = '{64'h00FF5AA501020300, 8, 1, 0, 24'h030201};
        vecs[2] = '{64'hA501020355000000, 5, 0, 1, 24'h030201};
        vecs[3] = '{64'hA5A5A50101000000, 5, 1, 0, 24'h01A5A5};
        vecs[4] = '{64'hA5123456A5000000, 5, 0, 1, 24'h01A5A5};
        vecs[5] = '{64'hA510203000000000, 5, 1, 0, 24'h302010};

        rst = 1'b1; rx_empty = 1'b1; r_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_payload", 32'(payload), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_link", 32'(link_up), 32'h0);
        check("rst_chk_err", 32'(chk_err), 32'h0);
        check("rst_to_err", 32'(to_err), 32'h0);
        check("rst_chk_cnt", 32'(chk_err_cnt), 32'h0);
        check("rst_to_cnt", 32'(to_err_cnt), 32'h0);
        check("rd_idle", 32'(rd_uart), 32'h0);
        rx_empty = 1'b0; r_data = 8'h00; #1;
        check("rd_busy", 32'(rd_uart), 32'h1);
        @(posedge clk); #1;
        rx_empty = 1'b1; #1;
        check("rd_idle2", 32'(rd_uart), 32'h0);

        // Latency: frame_valid and new payload one cycle after the checksum pop
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("lat_fv_early", 32'(frame_valid), 32'h0);
        send_byte(8'h00);
        check("lat_fv", 32'(frame_valid), 32'h1);
        check("lat_payload", 32'(payload), 32'h332211);
        check("lat_link", 32'(link_up), 32'h1);
        idle(1);
        check("lat_fv_drop", 32'(frame_valid), 32'h0);

        // Table-driven byte streams
        for (int v = 0; v < 6; v++) begin
            fv0 = fv_seen; ce0 = ce_seen; te0 = te_seen;
            for (int i = 0; i < vecs[v].n; i++) begin
                b = vecs[v].bytes[63-8*i -: 8];
                send_byte(b);
            end
            idle(3);
            check($sformatf("v%0d_fv", v), 32'(fv_seen - fv0), 32'(vecs[v].exp_fv));
            check($sformatf("v%0d_ce", v), 32'(ce_seen - ce0), 32'(vecs[v].exp_ce));
            check($sformatf("v%0d_te", v), 32'(te_seen - te0), 32'h0);
            check($sformatf("v%0d_payload", v), 32'(payload), 32'(vecs[v].exp_payload));
            check($sformatf("v%0d_link", v), 32'(link_up), 32'h1);
        end

        // Byte arriving on the expiry cycle wins: no timeout
        te0 = te_seen;
        send_byte(8'hA5); send_byte(8'h01);
        idle(BT - 1);
        send_byte(8'h0C); send_byte(8'h30); send_byte(8'h3D);
        check("edge_fv", 32'(frame_valid), 32'h1);
        check("edge_payload", 32'(payload), 32'h300C01);
        idle(2);
        check("edge_no_to", 32'(te_seen - te0), 32'h0);

        // Full silence of BT cycles aborts the frame
        send_byte(8'hA5); send_byte(8'h01);
        idle(BT);
        check("to_pulse", 32'(to_err), 32'h1);
        idle(1);
        check("to_pulse_drop", 32'(to_err), 32'h0);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
        check("to_next_fv", 32'(frame_valid), 32'h1);
        check("to_next_payload", 32'(payload), 32'h060504);
        idle(2);
        check("to_count", 32'(te_seen - te0), 32'h1);

        // Statistics counters (zero in the default build)
        check("stat_chk_cnt", 32'(chk_err_cnt), STATS ? 32'h2 : 32'h0);
        check("stat_to_cnt", 32'(to_err_cnt), STATS ? 32'h1 : 32'h0);

        // Link timeout boundary
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h00);
        idle(LT - 1);
        check("link_hold", 32'(link_up), 32'h1);
        idle(1);
        check("link_drop", 32'(link_up), 32'h0);
        idle(5);
        check("link_stay_low", 32'(link_up), 32'h0);

        // Good frame, then reset mid-frame
        send_byte(8'hA5); send_byte(8'h21); send_byte(8'h43); send_byte(8'h65); send_byte(8'h07);
        check("pre_rst_payload", 32'(payload), 32'h654321);
        check("pre_rst_link", 32'(link_up), 32'h1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_payload", 32'(payload), 32'h0);
        check("mid_rst_link", 32'(link_up), 32'h0);
        check("mid_rst_pulses", {29'h0, frame_valid, chk_err, to_err}, 32'h0);
        check("mid_rst_chk_cnt", 32'(chk_err_cnt), 32'h0);
        check("mid_rst_to_cnt", 32'(to_err_cnt), 32'h0);
        fv0 = fv_seen; ce0 = ce_seen;
        send_byte(8'h03); send_byte(8'h00);
        idle(3);
        check("tail_no_fv", 32'(fv_seen - fv0), 32'h0);
        check("tail_no_ce", 32'(ce_seen - ce0), 32'h0);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h08); send_byte(8'h09); send_byte(8'h06);
        check("post_rst_fv", 32'(frame_valid), 32'h1);
        check("post_rst_payload", 32'(payload), 32'h090807);
        check("post_rst_link", 32'(link_up), 32'h1);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
